fetch_unit: RTL and testbench

// - IF stage of the 5-stage 16-bit WISC pipeline. Produces instruction, currPC and new_addr (PC+2) for the IF/ID boundary.
// - Drives a multi-cycle instruction memory: request, then wait for done.
// - Consumes the decode-side feedback signals: stall, flush/nextPC redirect and HALT.
// - Invalid slots carry the NOP encoding.

---
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the WISC IF stage and imem.
// The master side (fetch unit) raises imem_rd/imem_addr; the slave answers with imem_data/imem_done.
interface fetch_unit_if;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;

  modport master (
    output imem_rd,
    output imem_addr,
    input  imem_data,
    input  imem_done
  );

  modport slave (
    input  imem_rd,
    input  imem_addr,
    output imem_data,
    output imem_done
  );
endinterface

// File: rtl/fetch_unit.sv
// IF stage of the 5-stage 16-bit WISC pipeline: multi-cycle imem fetch, stall skid, flush/halt handling.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic [15:0]         nextPC,
  input  logic                halt,
  fetch_unit_if.master        imem,
  output logic [15:0]         instruction,
  output logic [15:0]         currPC,
  output logic [15:0]         new_addr,
  output logic                valid,
  output logic                err,
  output logic [15:0]         fetch_cnt,
  output logic [15:0]         bubble_cnt
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] req_addr, req_addr_nxt;
  logic [15:0] skid_data, skid_data_nxt;
  logic [15:0] skid_pc, skid_pc_nxt;
  logic        discard, discard_nxt;
  logic        err_nxt;

  logic        rd;
  logic [15:0] addr;
  logic        load;
  logic [15:0] load_instr;
  logic [15:0] load_pc;
  logic        take_halt;
  logic        flush_eff;

  logic [15:0] ifid_instr_nxt;
  logic [15:0] ifid_pc_nxt;
  logic [15:0] ifid_naddr_nxt;
  logic        ifid_valid_nxt;

  assign imem.imem_rd   = rd;
  assign imem.imem_addr = addr;

  // HALTED swallows every redirect; halt needs a real instruction in IF/ID and yields to flush.
  assign flush_eff = flush && (state != HALTED);
  assign take_halt = halt && valid && !flush;

  // WAIT and HOLD are always entered with a bubble in IF/ID, so halt can only be seen in FETCH.
  // The skid buffer is occupied exactly while in HOLD; leaving HOLD empties it.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    req_addr_nxt  = req_addr;
    skid_data_nxt = skid_data;
    skid_pc_nxt   = skid_pc;
    discard_nxt   = discard;
    err_nxt       = err;
    rd            = 1'b0;
    addr          = pc;
    load          = 1'b0;
    load_instr    = imem.imem_data;
    load_pc       = pc;

    case (state)
      FETCH: begin
        if (flush) begin
          pc_nxt = nextPC;
        end else if (take_halt) begin
          state_nxt = HALTED;
        end else if (!stall) begin
          if (pc[0]) begin
            err_nxt   = 1'b1;
            state_nxt = HALTED;
          end else begin
            rd = 1'b1;
            if (imem.imem_done) begin
              load   = 1'b1;
              pc_nxt = pc + 16'd2;
            end else begin
              req_addr_nxt = pc;
              state_nxt    = WAIT;
            end
          end
        end
      end

      WAIT: begin
        // The access cannot be aborted, so the address stays pinned to the original request.
        rd   = 1'b1;
        addr = req_addr;
        if (flush) begin
          pc_nxt      = nextPC;
          discard_nxt = !imem.imem_done;
          if (imem.imem_done) state_nxt = FETCH;
        end else if (imem.imem_done) begin
          if (discard) begin
            discard_nxt = 1'b0;
            state_nxt   = FETCH;
          end else begin
            pc_nxt  = req_addr + 16'd2;
            load_pc = req_addr;
            if (stall) begin
              skid_data_nxt = imem.imem_data;
              skid_pc_nxt   = req_addr;
              state_nxt     = HOLD;
            end else begin
              load      = 1'b1;
              state_nxt = FETCH;
            end
          end
        end
      end

      HOLD: begin
        if (flush) begin
          pc_nxt    = nextPC;
          state_nxt = FETCH;
        end else if (!stall) begin
          load       = 1'b1;
          load_instr = skid_data;
          load_pc    = skid_pc;
          state_nxt  = FETCH;
        end
      end

      HALTED: begin
        state_nxt = HALTED;
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // IF/ID: flush/halt force a NOP, a fetch loads, an unstalled cycle with nothing to load drains to a bubble.
  always_comb begin
    ifid_instr_nxt = instruction;
    ifid_pc_nxt    = currPC;
    ifid_naddr_nxt = new_addr;
    ifid_valid_nxt = valid;
    if (flush_eff || (state_nxt == HALTED)) begin
      ifid_instr_nxt = NOP_INSTR;
      ifid_valid_nxt = 1'b0;
    end else if (load) begin
      ifid_instr_nxt = load_instr;
      ifid_pc_nxt    = load_pc;
      ifid_naddr_nxt = load_pc + 16'd2;
      ifid_valid_nxt = 1'b1;
    end else if (!stall) begin
      ifid_instr_nxt = NOP_INSTR;
      ifid_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      skid_data <= NOP_INSTR;
      skid_pc   <= 16'h0000;
      discard   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      req_addr  <= req_addr_nxt;
      skid_data <= skid_data_nxt;
      skid_pc   <= skid_pc_nxt;
      discard   <= discard_nxt;
      err       <= err_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= NOP_INSTR;
      currPC      <= 16'h0000;
      new_addr    <= 16'h0000;
      valid       <= 1'b0;
    end else begin
      instruction <= ifid_instr_nxt;
      currPC      <= ifid_pc_nxt;
      new_addr    <= ifid_naddr_nxt;
      valid       <= ifid_valid_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_q;
  logic [15:0] bubble_q;

  // Both counters saturate rather than wrap so a long run never reads back as small.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_q  <= 16'h0000;
      bubble_q <= 16'h0000;
    end else begin
      if (ifid_valid_nxt && load && (fetch_q != 16'hFFFF))
        fetch_q <= fetch_q + 16'd1;
      if (!valid && (state != HALTED) && (bubble_q != 16'hFFFF))
        bubble_q <= bubble_q + 16'd1;
    end
  end

  assign fetch_cnt  = fetch_q;
  assign bubble_cnt = bubble_q;
`else
  assign fetch_cnt  = 16'h0000;
  assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for the WISC fetch_unit: hit stream, miss, stall skid, flush, wrap, halt, err.
module tb_fetch_unit;

  typedef struct {
    logic        st;
    logic        fl;
    logic [15:0] npc;
    logic        hl;
    logic        dn;
    logic [15:0] dat;
    logic        e_rd;
    logic [15:0] e_addr;
    logic [15:0] e_ins;
    logic [15:0] e_cpc;
    logic [15:0] e_nad;
    logic        e_vld;
    logic        e_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] nextPC = 16'h0000;
  logic        halt = 1'b0;
  logic [15:0] instruction;
  logic [15:0] currPC;
  logic [15:0] new_addr;
  logic        valid;
  logic        err;
  logic [15:0] fetch_cnt;
  logic [15:0] bubble_cnt;

  int total = 0;
  int bad   = 0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .nextPC      (nextPC),
    .halt        (halt),
    .imem        (bus.master),
    .instruction (instruction),
    .currPC      (currPC),
    .new_addr    (new_addr),
    .valid       (valid),
    .err         (err),
    .fetch_cnt   (fetch_cnt),
    .bubble_cnt  (bubble_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(logic st, logic fl, logic [15:0] npc, logic hl, logic dn,
                              logic [15:0] dat, logic e_rd, logic [15:0] e_addr,
                              logic [15:0] e_ins, logic [15:0] e_cpc, logic [15:0] e_nad,
                              logic e_vld, logic e_err);
    vec_t v;
    v.st = st; v.fl = fl; v.npc = npc; v.hl = hl; v.dn = dn; v.dat = dat;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_ins = e_ins; v.e_cpc = e_cpc;
    v.e_nad = e_nad; v.e_vld = e_vld; v.e_err = e_err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called on a falling edge: drive, check request outputs, clock, check IF/ID, return at next falling edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    stall         = v.st;
    flush         = v.fl;
    nextPC        = v.npc;
    halt          = v.hl;
    bus.imem_done = v.dn;
    bus.imem_data = v.dat;
    #1;
    checkOutput({tag, " imem_rd"},   {15'd0, bus.imem_rd}, {15'd0, v.e_rd});
    checkOutput({tag, " imem_addr"}, bus.imem_addr, v.e_addr);
    @(posedge clk);
    #1;
    checkOutput({tag, " instruction"}, instruction, v.e_ins);
    checkOutput({tag, " currPC"},      currPC, v.e_cpc);
    checkOutput({tag, " new_addr"},    new_addr, v.e_nad);
    checkOutput({tag, " valid"},       {15'd0, valid}, {15'd0, v.e_vld});
    checkOutput({tag, " err"},         {15'd0, err}, {15'd0, v.e_err});
    @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " instruction"}, instruction, 16'h0800);
    checkOutput({tag, " currPC"},      currPC, 16'h0000);
    checkOutput({tag, " new_addr"},    new_addr, 16'h0000);
    checkOutput({tag, " valid"},       {15'd0, valid}, 16'h0000);
    checkOutput({tag, " err"},         {15'd0, err}, 16'h0000);
  endtask

  task automatic doReset(input string tag);
    stall = 1'b0; flush = 1'b0; halt = 1'b0; nextPC = 16'h0000;
    bus.imem_done = 1'b0; bus.imem_data = 16'h0000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkReset(tag);
  endtask

  vec_t vecs[26];

  initial begin
    //            st fl npc       hl dn dat       rd addr      ins       cpc       nad       v  e
    // hit stream
    vecs[0]  = mk(0, 0, 16'h0000, 0, 1, 16'h1000, 1, 16'h0000, 16'h1000, 16'h0000, 16'h0002, 1, 0);
    vecs[1]  = mk(0, 0, 16'h0000, 0, 1, 16'h1002, 1, 16'h0002, 16'h1002, 16'h0002, 16'h0004, 1, 0);
    vecs[2]  = mk(0, 0, 16'h0000, 0, 1, 16'h1004, 1, 16'h0004, 16'h1004, 16'h0004, 16'h0006, 1, 0);
    vecs[3]  = mk(0, 0, 16'h0000, 0, 1, 16'h1006, 1, 16'h0006, 16'h1006, 16'h0006, 16'h0008, 1, 0);
    // miss at PC=8, done three cycles late
    vecs[4]  = mk(0, 0, 16'h0000, 0, 0, 16'hBAD0, 1, 16'h0008, 16'h0800, 16'h0006, 16'h0008, 0, 0);
    vecs[5]  = mk(0, 0, 16'h0000, 0, 0, 16'hBAD1, 1, 16'h0008, 16'h0800, 16'h0006, 16'h0008, 0, 0);
    vecs[6]  = mk(0, 0, 16'h0000, 0, 0, 16'hBAD2, 1, 16'h0008, 16'h0800, 16'h0006, 16'h0008, 0, 0);
    vecs[7]  = mk(0, 0, 16'h0000, 0, 1, 16'h2008, 1, 16'h0008, 16'h2008, 16'h0008, 16'h000A, 1, 0);
    // stall while waiting; done lands in the skid buffer
    vecs[8]  = mk(0, 0, 16'h0000, 0, 0, 16'hBAD3, 1, 16'h000A, 16'h0800, 16'h0008, 16'h000A, 0, 0);
    vecs[9]  = mk(1, 0, 16'h0000, 0, 0, 16'hBAD4, 1, 16'h000A, 16'h0800, 16'h0008, 16'h000A, 0, 0);
    vecs[10] = mk(1, 0, 16'h0000, 0, 1, 16'h300A, 1, 16'h000A, 16'h0800, 16'h0008, 16'h000A, 0, 0);
    vecs[11] = mk(1, 0, 16'h0000, 0, 0, 16'hBAD5, 0, 16'h000C, 16'h0800, 16'h0008, 16'h000A, 0, 0);
    vecs[12] = mk(0, 0, 16'h0000, 0, 0, 16'hBAD6, 0, 16'h000C, 16'h300A, 16'h000A, 16'h000C, 1, 0);
    vecs[13] = mk(0, 0, 16'h0000, 0, 1, 16'h400C, 1, 16'h000C, 16'h400C, 16'h000C, 16'h000E, 1, 0);
    // stall in FETCH holds a valid IF/ID and issues nothing
    vecs[14] = mk(1, 0, 16'h0000, 0, 1, 16'h5555, 0, 16'h000E, 16'h400C, 16'h000C, 16'h000E, 1, 0);
    // flush mid-miss: in-flight data dropped, restart at 0x0040
    vecs[15] = mk(0, 0, 16'h0000, 0, 0, 16'hBAD7, 1, 16'h000E, 16'h0800, 16'h000C, 16'h000E, 0, 0);
    vecs[16] = mk(0, 1, 16'h0040, 0, 0, 16'hBAD8, 1, 16'h000E, 16'h0800, 16'h000C, 16'h000E, 0, 0);
    vecs[17] = mk(0, 0, 16'h0000, 0, 0, 16'hBAD9, 1, 16'h000E, 16'h0800, 16'h000C, 16'h000E, 0, 0);
    vecs[18] = mk(0, 0, 16'h0000, 0, 1, 16'hDEAD, 1, 16'h000E, 16'h0800, 16'h000C, 16'h000E, 0, 0);
    vecs[19] = mk(0, 0, 16'h0000, 0, 1, 16'h5040, 1, 16'h0040, 16'h5040, 16'h0040, 16'h0042, 1, 0);
    // wrap: redirect to 0xFFFE, hit there, next fetch at 0x0000
    vecs[20] = mk(0, 1, 16'hFFFE, 0, 0, 16'hBADA, 0, 16'h0042, 16'h0800, 16'h0040, 16'h0042, 0, 0);
    vecs[21] = mk(0, 0, 16'h0000, 0, 1, 16'h6FFE, 1, 16'hFFFE, 16'h6FFE, 16'hFFFE, 16'h0000, 1, 0);
    vecs[22] = mk(0, 0, 16'h0000, 0, 1, 16'h7000, 1, 16'h0000, 16'h7000, 16'h0000, 16'h0002, 1, 0);
    // halt with a valid slot; later flush ignored
    vecs[23] = mk(0, 0, 16'h0000, 1, 1, 16'h1234, 0, 16'h0002, 16'h0800, 16'h0000, 16'h0002, 0, 0);
    vecs[24] = mk(0, 1, 16'h0080, 0, 1, 16'h1235, 0, 16'h0002, 16'h0800, 16'h0000, 16'h0002, 0, 0);
    vecs[25] = mk(0, 0, 16'h0000, 0, 1, 16'h1236, 0, 16'h0002, 16'h0800, 16'h0000, 16'h0002, 0, 0);

    $display("[TB] reset and main vector table");
    doReset("reset0");
    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
`ifdef FETCH_PERF_CNT_EN
      if (i == 3) begin
        checkOutput("perf fetch_cnt after hits", fetch_cnt, 16'd4);
        checkOutput("perf bubble_cnt after hits", bubble_cnt, 16'd1);
      end
`endif
    end

    // Misaligned redirect: err set, no request ever issued, sticky until reset.
    $display("[TB] misaligned redirect");
    doReset("reset1");
    applyStimulus(mk(0, 1, 16'h0011, 0, 0, 16'h0000, 0, 16'h0000, 16'h0800, 16'h0000, 16'h0000, 0, 0), "w0");
    applyStimulus(mk(0, 0, 16'h0000, 0, 1, 16'hAAAA, 0, 16'h0011, 16'h0800, 16'h0000, 16'h0000, 0, 1), "w1");
    applyStimulus(mk(0, 1, 16'h0020, 0, 1, 16'hAAAB, 0, 16'h0011, 16'h0800, 16'h0000, 16'h0000, 0, 1), "w2");

    // Asynchronous reset in the middle of a miss.
    $display("[TB] reset mid-access");
    doReset("reset2");
    applyStimulus(mk(0, 0, 16'h0000, 0, 1, 16'h1111, 1, 16'h0000, 16'h1111, 16'h0000, 16'h0002, 1, 0), "r0");
    applyStimulus(mk(0, 0, 16'h0000, 0, 0, 16'hBADB, 1, 16'h0002, 16'h0800, 16'h0000, 16'h0002, 0, 0), "r1");
    rst = 1'b1;
    #1;
    checkOutput("async rst imem_addr", bus.imem_addr, 16'h0000);
    checkReset("async rst");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(mk(0, 0, 16'h0000, 0, 1, 16'h2222, 1, 16'h0000, 16'h2222, 16'h0000, 16'h0002, 1, 0), "r2");

`ifndef FETCH_PERF_CNT_EN
    checkOutput("fetch_cnt tied off", fetch_cnt, 16'h0000);
    checkOutput("bubble_cnt tied off", bubble_cnt, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
